// File: rtl/stream_matvec_dot_if.sv
// Valid/ready stream bundle used between the matrix-vector pipeline stages.
interface axi_stream_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport axi_in  (input tdata, input tvalid, input tlast, output tready);
  modport axi_out (output tdata, output tvalid, output tlast, input tready);
endinterface

// File: rtl/stream_matvec_dot.sv
// Row-wise dot product of a replayed vector stream against a row-major matrix
// stream; one signed accumulator word leaves per matrix row.
module stream_matvec_dot #(
  parameter int D_W          = 8,
  parameter int ACC_W        = 32,
  parameter int MATRIXSIZE_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_stream_if.axi_in            in_vec,
  axi_stream_if.axi_in            in_mat,
  axi_stream_if.axi_out           out_res,
  input  logic [MATRIXSIZE_W-1:0] DIM1,
  input  logic [MATRIXSIZE_W-1:0] DIM2,
  output logic                    err
);
  typedef enum logic [1:0] {S_RESET, S_IDLE, S_RUN} state_t;

  state_t                  state_reg, state_next;
  logic [MATRIXSIZE_W-1:0] dim1_reg, dim2_reg;
  logic [MATRIXSIZE_W-1:0] colcnt_reg, rowcnt_reg;
  logic signed [ACC_W-1:0] acc_reg, acc_next, out_data_reg, product_ext;
  logic signed [2*D_W-1:0] product;
  logic                    out_valid_reg, out_last_reg, err_reg;
  logic                    col_last, row_last, blocked, run, fire, frame_bad;

  assign col_last = (colcnt_reg == dim2_reg - MATRIXSIZE_W'(1));
  assign row_last = (rowcnt_reg == dim1_reg - MATRIXSIZE_W'(1));

  // Only the row-closing element needs the output register; earlier ones never stall.
  assign blocked = col_last & out_valid_reg & ~out_res.tready;

  assign product     = $signed(in_vec.tdata[D_W-1:0]) * $signed(in_mat.tdata[D_W-1:0]);
  assign product_ext = ACC_W'(product);
  assign acc_next    = ((colcnt_reg == '0) ? '0 : acc_reg) + product_ext;
  assign frame_bad   = (in_vec.tlast != (row_last & col_last)) |
                       (in_mat.tlast != (row_last & col_last));

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= S_RESET;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET: state_next = S_IDLE;
      S_IDLE:  if (in_vec.tvalid && in_mat.tvalid) state_next = S_RUN;
      S_RUN:   if (fire && col_last && row_last) state_next = S_IDLE;
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    run           = (state_reg == S_RUN);
    fire          = in_vec.tvalid & in_mat.tvalid & run & ~blocked;
    in_vec.tready = run & in_mat.tvalid & ~blocked;
    in_mat.tready = run & in_vec.tvalid & ~blocked;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dim1_reg      <= '0;
      dim2_reg      <= '0;
      colcnt_reg    <= '0;
      rowcnt_reg    <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && state_next == S_RUN) begin
        dim1_reg <= DIM1;
        dim2_reg <= DIM2;
      end
      if (fire) begin
        if (frame_bad) err_reg <= 1'b1;
        if (col_last) begin
          colcnt_reg    <= '0;
          rowcnt_reg    <= row_last ? '0 : rowcnt_reg + MATRIXSIZE_W'(1);
          out_data_reg  <= acc_next;
          out_valid_reg <= 1'b1;
          out_last_reg  <= row_last;
        end else begin
          colcnt_reg <= colcnt_reg + MATRIXSIZE_W'(1);
          acc_reg    <= acc_next;
        end
      end
      if (out_valid_reg && out_res.tready && !(fire && col_last))
        out_valid_reg <= 1'b0;
    end
  end

  assign out_res.tdata  = out_data_reg;
  assign out_res.tvalid = out_valid_reg;
  assign out_res.tlast  = out_last_reg;
  assign err            = err_reg;
endmodule

// File: tb/tb_stream_matvec_dot.sv
// Directed bench for stream_matvec_dot: hand-computed row sums, backpressure,
// input gaps, framing error and mid-product reset.
module tb_stream_matvec_dot;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] dim1 = 24'd2;
  logic [23:0] dim2 = 24'd3;
  logic        err;

  axi_stream_if #(.DATA_W(8))  vec_if ();
  axi_stream_if #(.DATA_W(8))  mat_if ();
  axi_stream_if #(.DATA_W(32)) res_if ();

  stream_matvec_dot #(.D_W(8), .ACC_W(32), .MATRIXSIZE_W(24)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vec  (vec_if),
    .in_mat  (mat_if),
    .out_res (res_if),
    .DIM1    (dim1),
    .DIM2    (dim2),
    .err     (err)
  );

  always #5 clk = ~clk;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic [7:0]  vdat [64];
  logic [7:0]  mdat [64];
  logic [31:0] exp_d [$];
  bit          exp_l [$];
  logic [31:0] obs_d [$];
  bit          obs_l [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs,
               $signed(expv), expv);
    end
  endtask

  task automatic exp_push(input int d, input bit l);
    exp_d.push_back(32'(d));
    exp_l.push_back(l);
  endtask

  task automatic compare(input string name);
    check({name, "_count"}, 32'(obs_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      check({name, "_data"}, obs_d[i], exp_d[i]);
      check({name, "_last"}, 32'(obs_l[i]), 32'(exp_l[i]));
    end
    obs_d.delete(); obs_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    vec_if.tvalid = 1'b1; mat_if.tvalid = 1'b1;
    vec_if.tdata = 8'd0;  mat_if.tdata = 8'd0;
    vec_if.tlast = 1'b0;  mat_if.tlast = 1'b0;
    res_if.tready = 1'b1;
    @(negedge clk); #1;
    check("rst_vec_tready", 32'(vec_if.tready), 0);
    check("rst_mat_tready", 32'(mat_if.tready), 0);
    check("rst_out_tvalid", 32'(res_if.tvalid), 0);
    check("rst_out_tlast", 32'(res_if.tlast), 0);
    check("rst_out_tdata", res_if.tdata, 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b1;
    @(negedge clk); #1;
    check("idle_tready", 32'(vec_if.tready), 0);
    @(negedge clk); #1;
    check("run_tready", 32'(vec_if.tready), 1);
    vec_if.tvalid = 1'b0; mat_if.tvalid = 1'b0;
  endtask

  // Feeds n element pairs of a d1 x d2 product and collects output words until
  // as many results as are expected have drained.
  task automatic run_stream(input int d1, input int d2, input int n, input int gap,
                            input int bad_idx, input bit stall, output int span);
    int  k = 0, cyc = 0, stall_cnt = 0, first = -1, last = -1;
    int  rows_exp;
    bit  vv = 0, mv = 0, stalled = 0, fire_v, fire_m, in_stall;
    rows_exp = exp_d.size();
    dim1 = 24'(d1);
    dim2 = 24'(d2);
    while ((k < n || obs_d.size() < rows_exp) && cyc < 3000) begin
      @(negedge clk);
      if (k < n) begin
        if (!vv) vv = (gap == 0) || ($urandom_range(99) >= gap);
        if (!mv) mv = (gap == 0) || ($urandom_range(99) >= gap);
      end
      vec_if.tvalid = vv;
      mat_if.tvalid = mv;
      vec_if.tdata  = vdat[k];
      mat_if.tdata  = mdat[k];
      vec_if.tlast  = (k == d1 * d2 - 1);
      mat_if.tlast  = (bad_idx >= 0) ? (k == bad_idx) : (k == d1 * d2 - 1);
      if (stall && !stalled && res_if.tvalid) begin
        stalled   = 1;
        stall_cnt = 5;
      end
      res_if.tready = (stall_cnt == 0);
      #1;
      in_stall = (stall_cnt > 0);
      if (in_stall) begin
        check("hold_valid", 32'(res_if.tvalid), 1);
        check("hold_data", res_if.tdata, exp_d[0]);
        check("hold_last", 32'(res_if.tlast), 0);
        stall_cnt--;
      end
      fire_v = vv & vec_if.tready;
      fire_m = mv & mat_if.tready;
      if (gap > 0) check("pair_fire", 32'(fire_v), 32'(fire_m));
      if (res_if.tvalid && res_if.tready) begin
        obs_d.push_back(res_if.tdata);
        obs_l.push_back(res_if.tlast);
        $display("out word %0d: data=%0d last=%0d", obs_d.size() - 1,
                 $signed(res_if.tdata), res_if.tlast);
      end
      if (fire_v) begin
        if (in_stall) check("stall_closing_fire", 32'(k % d2 == d2 - 1), 0);
        if (first < 0) first = cyc;
        last = cyc;
        k++;
        vv = 0;
        mv = 0;
      end
      cyc++;
    end
    if (cyc >= 3000) check("timeout", 1, 0);
    vec_if.tvalid = 1'b0;
    mat_if.tvalid = 1'b0;
    res_if.tready = 1'b1;
    span = last - first + 1;
  endtask

  initial begin
    int span;
    int v1[3] = '{1, 2, 3};
    int m1[6] = '{1, 1, 1, -1, 0, 2};
    int m3[8] = '{1, 2, 5, 0, -7, 3, 10, 10};
    int mr[4] = '{3, 4, 5, 6};
    int vrow[5];
    int s;
    vec_if.tvalid = 1'b0; mat_if.tvalid = 1'b0;
    res_if.tready = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // 2x3 basic product
    for (int k = 0; k < 6; k++) begin vdat[k] = 8'(v1[k % 3]); mdat[k] = 8'(m1[k]); end
    exp_push(6, 0); exp_push(5, 1);
    run_stream(2, 3, 6, 0, -1, 0, span);
    compare("basic");
    check("basic_err", 32'(err), 0);

    // Extremes, single-row products
    for (int k = 0; k < 4; k++) begin vdat[k] = 8'h80; mdat[k] = 8'h80; end
    exp_push(65536, 1);
    run_stream(1, 4, 4, 0, -1, 0, span);
    compare("ext_pos");
    for (int k = 0; k < 4; k++) begin vdat[k] = 8'h80; mdat[k] = 8'h7f; end
    exp_push(-65024, 1);
    run_stream(1, 4, 4, 0, -1, 0, span);
    compare("ext_neg");

    // Backpressure on the first result; vec (3,-2)
    for (int k = 0; k < 8; k++) begin vdat[k] = 8'((k % 2 == 0) ? 3 : -2); mdat[k] = 8'(m3[k]); end
    exp_push(-1, 0); exp_push(15, 0); exp_push(-27, 0); exp_push(10, 1);
    run_stream(4, 2, 8, 0, -1, 1, span);
    compare("bp");

    // DIM2 = 1: one product per row, one pair per cycle
    for (int k = 0; k < 3; k++) vdat[k] = 8'(-3);
    mdat[0] = 8'(4); mdat[1] = 8'(-5); mdat[2] = 8'(7);
    exp_push(-12, 0); exp_push(15, 0); exp_push(-21, 1);
    run_stream(3, 1, 3, 0, -1, 0, span);
    compare("dim2_1");
    check("dim2_1_span", 32'(span), 3);

    // Random gaps on both inputs, 8x5
    for (int c = 0; c < 5; c++) vrow[c] = $signed(8'($urandom_range(255)));
    for (int r = 0; r < 8; r++) begin
      s = 0;
      for (int c = 0; c < 5; c++) begin
        vdat[r * 5 + c] = 8'(vrow[c]);
        mdat[r * 5 + c] = 8'($urandom_range(255));
        s += vrow[c] * $signed(mdat[r * 5 + c]);
      end
      exp_push(s, r == 7);
    end
    run_stream(8, 5, 40, 30, -1, 0, span);
    compare("gaps");
    check("gaps_err", 32'(err), 0);

    // Framing: in_mat.tlast on element 1 of a 2x2 product
    for (int k = 0; k < 4; k++) begin vdat[k] = 8'((k % 2 == 0) ? 1 : 2); mdat[k] = 8'(mr[k]); end
    exp_push(11, 0); exp_push(17, 1);
    run_stream(2, 2, 4, 0, 1, 0, span);
    compare("frame");
    check("frame_err", 32'(err), 1);
    repeat (3) @(negedge clk);
    #1 check("frame_err_sticky", 32'(err), 1);

    // Reset after two elements of row 0, then a clean product
    for (int k = 0; k < 6; k++) begin vdat[k] = 8'(v1[k % 3]); mdat[k] = 8'(m1[k]); end
    run_stream(2, 3, 2, 0, -1, 0, span);
    check("partial_none_out", 32'(obs_d.size()), 0);
    do_reset();
    exp_push(6, 0); exp_push(5, 1);
    run_stream(2, 3, 6, 0, -1, 0, span);
    compare("after_rst");
    check("after_rst_err", 32'(err), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
